lcd_frame_source: RTL
=====================

Name: lcd_frame_source

Overview:
- Upstream pixel producer for the 8080-style LCD write engine.
- Emits one RGB565 word per transfer, plus start-of-frame and end-of-frame markers, over a valid/ready handshake.
- Each frame starts only on a rising edge of the panel tearing-effect line (FMARK), so writes never tear.
- Draws a white border with a red column cursor and a blue row cursor that advance one step per completed frame.

Parameters:
- WIDTH, 320: pixels along x (outer scan counter).
- HEIGHT, 240: pixels along y (inner scan counter, increments fastest, matching the MV-rotated memory write).
- WAIT_FMARK, 1: 1 = each frame waits for an FMARK rising edge; 0 = frames start back-to-back.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  level; high = produce frames
- i_lcd_fmark  in  1  tearing-effect line from panel, asynchronous
- o_pixel  out  16  RGB565 pixel word
- o_valid  out  1  o_pixel valid
- i_ready  in  1  consumer accepts o_pixel
- o_sof  out  1  qualifies o_valid; high on pixel (0,0)
- o_eof  out  1  qualifies o_valid; high on pixel (WIDTH-1,HEIGHT-1)
- o_busy  out  1  high while in STREAM
- o_tear_miss  out  1  one-cycle pulse: FMARK edge seen while still in STREAM
- o_frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE; o_valid, o_sof, o_eof, o_busy, o_tear_miss = 0; o_pixel=16'h0000; o_frame_count=0.
  - x=y=0; cursor cx=cy=0; synchroniser flops=0.
- FMARK handling: two-flop synchroniser, then a rising-edge detect against a third flop. A pin edge becomes an internal pulse on the 3rd clock edge after the pin rises.
- States:
  - IDLE: o_valid=0. If i_enable=1 -> WAIT (WAIT_FMARK=1) or STREAM (WAIT_FMARK=0).
  - WAIT: if i_enable=0 -> IDLE. On FMARK pulse -> STREAM with x=y=0. o_valid rises the cycle after the pulse.
  - STREAM: o_valid=1, o_busy=1.
    - Transfer occurs only when o_valid && i_ready. On transfer: y++; at y=HEIGHT-1, y=0 and x++.
    - On the transfer of (WIDTH-1, HEIGHT-1): -> END.
  - END (one cycle, o_valid=0):
    - o_frame_count++.
    - cx = (cx==WIDTH-1) ? 0 : cx+1.
    - cy = (cy==HEIGHT-1) ? 0 : cy+1.
    - Then -> WAIT/STREAM if i_enable=1, else IDLE.
- Stall rule: while o_valid=1 && i_ready=0, o_pixel, o_sof and o_eof hold stable. o_valid never deasserts mid-frame.
- Pixel colour, priority order, registered with the coordinates it belongs to:
  1. Border (x==0, y==0, x==WIDTH-1 or y==HEIGHT-1): 16'hFFFF.
  2. x==cx: 16'hF800.
  3. y==cy: 16'h001F.
  4. Otherwise: 16'h0000.
- Counters: x, y, cx and cy are each $clog2 of their dimension wide. Compares use full width. No overflow beyond the wrap points.
- i_enable falling mid-STREAM: the current frame completes, then -> IDLE.
- FMARK pulse during STREAM or END: ignored for framing; o_tear_miss pulses 1 cycle.
- FMARK pulse in the same cycle END exits to WAIT: not captured; the next edge starts the frame.
- i_ready held high: one pixel per clock. Frame length is exactly WIDTH*HEIGHT transfers.

Decomposition:
- Shared package lcd_pkg holds:
  - RGB565 constants: COL_WHITE=FFFF, COL_RED=F800, COL_BLUE=001F, COL_BLACK=0000.
  - Default panel WIDTH and HEIGHT.
  - State enum (IDLE, WAIT, STREAM, END).
- One sub-module, lcd_sync_edge: 2-flop synchroniser plus rising-edge pulse, async active-low reset. The later LCD write engine reuses it for its own FMARK use.

Test Plan:
- Reset: assert i_reset_n=0 mid-STREAM -> o_valid, o_busy and o_frame_count are 0 immediately (asynchronously, no clock edge needed). After release, stays IDLE while i_enable=0.
- Frame start (WIDTH=4, HEIGHT=3, i_ready=1): FMARK rises -> o_valid rises 4 clocks after the pin edge, with o_sof=1 and o_pixel=FFFF. Exactly 12 transfers follow, with o_eof on the 12th. o_frame_count 0->1.
- Pattern (WIDTH=4, HEIGHT=3): frame 2 (cx=1, cy=1) -> pixel (1,1)=FFFF is wrong by border rule? No: (1,1) is interior, so (1,1)=F800 (red beats blue). Sequence x=1: y=0 FFFF, y=1 F800, y=2 FFFF.
- Backpressure: drive i_ready with a 1-of-3 pattern -> o_pixel stable across all stalled cycles. Still 12 transfers per frame, none lost or duplicated.
- Tear miss: hold i_ready=0 for 100 cycles mid-frame and pulse FMARK -> o_tear_miss high exactly 1 cycle. Frame completes normally; the next frame waits for a fresh edge.
- Wrap and disable: run 256 frames -> o_frame_count returns to 0, and cx wraps 3->0 after frame 4. Drop i_enable mid-frame -> the frame finishes with o_eof, then IDLE with no further o_valid despite FMARK edges.

Source files
------------

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Definitions shared by the LCD frame source and the 8080 LCD write engine:
// the default panel geometry, the RGB565 colours used by the test pattern,
// and the frame source state encoding.
// ---------------------------------------------------------------------------
package lcd_pkg;

    // Default panel geometry: 320 columns (x), 240 rows (y)
    localparam int LCD_WIDTH  = 320;
    localparam int LCD_HEIGHT = 240;

    // RGB565 colours
    localparam logic [15:0] COL_WHITE = 16'hFFFF;
    localparam logic [15:0] COL_RED   = 16'hF800;
    localparam logic [15:0] COL_BLUE  = 16'h001F;
    localparam logic [15:0] COL_BLACK = 16'h0000;

    // Frame source states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM,
        ST_END
    } lcd_state_e;

endpackage

// File: rtl/lcd_frame_source_if.sv
// ---------------------------------------------------------------------------
// lcd_frame_source_if
// Pixel stream from the frame source to the LCD write engine.
//   o_pixel  RGB565 word
//   o_valid  o_pixel is valid
//   i_ready  consumer accepts o_pixel (a transfer is o_valid && i_ready)
//   o_sof    qualifies o_valid, first pixel of a frame
//   o_eof    qualifies o_valid, last pixel of a frame
// master = pixel producer, slave = pixel consumer.
// ---------------------------------------------------------------------------
interface lcd_frame_source_if;

    logic [15:0] o_pixel;
    logic        o_valid;
    logic        i_ready;
    logic        o_sof;
    logic        o_eof;

    modport master (
        output o_pixel,
        output o_valid,
        output o_sof,
        output o_eof,
        input  i_ready
    );

    modport slave (
        input  o_pixel,
        input  o_valid,
        input  o_sof,
        input  o_eof,
        output i_ready
    );

endinterface

// File: rtl/lcd_sync_edge.sv
// ---------------------------------------------------------------------------
// lcd_sync_edge
// Brings an asynchronous level (the panel FMARK line) into the i_clk domain
// and turns each rising edge into a single-cycle pulse.
//   i_clk      system clock
//   i_reset_n  asynchronous, active-low reset
//   i_async    asynchronous input level
//   o_pulse    one-cycle pulse, high after the 3rd clock edge following
//              the rising edge of i_async
// ---------------------------------------------------------------------------
module lcd_sync_edge (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    // Two metastability flops, then a third flop holding the previous
    // synchronised level. The edge pulse is registered so downstream logic
    // sees a clean flop output one edge after the synchronised level rises.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            sync_3  <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            sync_1  <= i_async;
            sync_2  <= sync_1;
            sync_3  <= sync_2;
            o_pulse <= sync_2 & ~sync_3;
        end
    end

endmodule

// File: rtl/lcd_frame_source.sv
// ---------------------------------------------------------------------------
// lcd_frame_source
// Pixel producer for the 8080 LCD write engine. Scans y fastest, then x,
// and draws a white border with a red column cursor (cx) and a blue row
// cursor (cy) that step once per completed frame. With WAIT_FMARK=1 every
// frame starts on a rising edge of the panel tearing-effect line.
//   i_clk          system clock
//   i_reset_n      asynchronous, active-low reset
//   i_enable       level, high = produce frames
//   i_lcd_fmark    tearing-effect line from the panel (asynchronous)
//   pix_if         pixel stream (master side)
//   o_busy         high while streaming a frame
//   o_tear_miss    one-cycle pulse, FMARK edge seen while a frame is active
//   o_frame_count  completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module lcd_frame_source
    import lcd_pkg::*;
#(
    parameter int WIDTH      = LCD_WIDTH,
    parameter int HEIGHT     = LCD_HEIGHT,
    parameter bit WAIT_FMARK = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_lcd_fmark,
    lcd_frame_source_if.master   pix_if,
    output logic                 o_busy,
    output logic                 o_tear_miss,
    output logic [7:0]           o_frame_count
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    lcd_state_e    state_q;
    lcd_state_e    state_d;
    logic          fmark_pulse;
    logic          xfer;
    logic          last_pixel;
    logic          start_stream;
    logic [XW-1:0] x_q;
    logic [XW-1:0] next_x;
    logic [XW-1:0] cx_q;
    logic [YW-1:0] y_q;
    logic [YW-1:0] next_y;
    logic [YW-1:0] cy_q;
    logic [15:0]   pixel_q;
    logic          sof_q;
    logic          eof_q;
    logic          tear_q;
    logic [7:0]    frame_count_q;

    // Test pattern colour for one coordinate; border wins over the red
    // column cursor, which wins over the blue row cursor.
    function automatic logic [15:0] pixel_colour(
        input logic [XW-1:0] px,
        input logic [YW-1:0] py,
        input logic [XW-1:0] ccx,
        input logic [YW-1:0] ccy
    );
        logic [15:0] colour;
        if (px == '0 || py == '0 || px == X_LAST || py == Y_LAST) begin
            colour = COL_WHITE;
        end else if (px == ccx) begin
            colour = COL_RED;
        end else if (py == ccy) begin
            colour = COL_BLUE;
        end else begin
            colour = COL_BLACK;
        end
        return colour;
    endfunction

    lcd_sync_edge u_fmark_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_lcd_fmark),
        .o_pulse   (fmark_pulse)
    );

    assign xfer         = (state_q == ST_STREAM) && pix_if.i_ready;
    assign last_pixel   = (x_q == X_LAST) && (y_q == Y_LAST);
    assign start_stream = (state_d == ST_STREAM) && (state_q != ST_STREAM);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. WAIT only looks at the FMARK pulse while it is
    // actually in WAIT, so a pulse landing in the cycle END hands over to
    // WAIT is dropped and the frame waits for the following edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = WAIT_FMARK ? ST_WAIT : ST_STREAM;
                end
            end
            ST_WAIT: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (fmark_pulse) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer && last_pixel) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                if (i_enable) begin
                    state_d = WAIT_FMARK ? ST_WAIT : ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: valid is a pure decode of the state register, so it is
    // glitch-free and never drops until the last pixel has transferred.
    always_comb begin
        pix_if.o_valid = (state_q == ST_STREAM);
        pix_if.o_pixel = pixel_q;
        pix_if.o_sof   = sof_q;
        pix_if.o_eof   = eof_q;
        o_busy         = (state_q == ST_STREAM);
        o_tear_miss    = tear_q;
        o_frame_count  = frame_count_q;
    end

    // Scan coordinate after the current one: y is the inner counter.
    always_comb begin
        next_x = x_q;
        next_y = y_q + YW'(1);
        if (y_q == Y_LAST) begin
            next_y = '0;
            next_x = x_q + XW'(1);
        end
    end

    // Presented pixel and its coordinates. Everything here only changes on
    // frame start or on an accepted transfer, which keeps the word and its
    // markers stable while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            pixel_q <= COL_BLACK;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (start_stream) begin
            x_q     <= '0;
            y_q     <= '0;
            pixel_q <= pixel_colour('0, '0, cx_q, cy_q);
            sof_q   <= 1'b1;
            eof_q   <= (X_LAST == '0) && (Y_LAST == '0);
        end else if (xfer) begin
            sof_q <= 1'b0;
            if (last_pixel) begin
                eof_q <= 1'b0;
            end else begin
                x_q     <= next_x;
                y_q     <= next_y;
                pixel_q <= pixel_colour(next_x, next_y, cx_q, cy_q);
                eof_q   <= (next_x == X_LAST) && (next_y == Y_LAST);
            end
        end
    end

    // Per-frame bookkeeping done in the single END cycle: count the frame
    // and step both cursors with wrap at the panel edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_count_q <= 8'd0;
            cx_q          <= '0;
            cy_q          <= '0;
        end else if (state_q == ST_END) begin
            frame_count_q <= frame_count_q + 8'd1;
            cx_q          <= (cx_q == X_LAST) ? '0 : cx_q + XW'(1);
            cy_q          <= (cy_q == Y_LAST) ? '0 : cy_q + YW'(1);
        end
    end

    // An FMARK edge arriving while a frame is still being written means the
    // panel refresh overtook us; flag it for one cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tear_q <= 1'b0;
        end else begin
            tear_q <= fmark_pulse && ((state_q == ST_STREAM) || (state_q == ST_END));
        end
    end

endmodule
